// File: rtl/tile_renderer.sv
// Tile-map pixel stage: maps h_cnt/v_cnt to a tile-ROM address and registers the returned colour.
// Optional GRID_OVERLAY_EN paints pixels on tile borders grey (12'h888).
module tile_renderer #(
    parameter int unsigned TILE_COLS = 20,
    parameter int unsigned TILE_ROWS = 15,
    parameter int unsigned ROM_LAT   = 1,
    parameter logic [3:0]  CLEAR_VAL = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        wr_en,
    input  logic [4:0]  wr_col,
    input  logic [3:0]  wr_row,
    input  logic [3:0]  wr_tile,
    output logic        busy,
    output logic [13:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue,
    output logic        hsync_out,
    output logic        vsync_out
);
    localparam int unsigned MAP_N = TILE_COLS * TILE_ROWS;
    localparam int unsigned L     = 2 + ROM_LAT;
    localparam int unsigned IDX_W = $clog2(16 * TILE_COLS + 32);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [3:0]       map_q [MAP_N];

    logic [4:0]       rd_col;
    logic [3:0]       rd_row;
    logic             rd_inr;
    logic [IDX_W-1:0] rd_idx;
    logic [3:0]       rd_tile;
    logic             wr_ok;
    logic [IDX_W-1:0] wr_idx;
    logic             vis_in;
    logic [11:0]      pix;

    logic [13:0]      rom_addr_q;
    logic [L-1:0]     vld_q, hs_q, vs_q;
    logic [11:0]      rgb_q;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == S_CLEAR) begin
            if (clr_idx_q == IDX_W'(MAP_N - 1)) begin
                state_d   = S_RUN;
                clr_idx_d = '0;
            end else begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign busy = (state_q == S_CLEAR);

    // Rows at v_cnt >= 512 are treated as off-map, keeping the map index in bounds.
    assign rd_col  = h_cnt[9:5];
    assign rd_row  = v_cnt[8:5];
    assign rd_inr  = !v_cnt[9] && (32'(rd_col) < TILE_COLS) && (32'(rd_row) < TILE_ROWS);
    assign rd_idx  = rd_inr ? (IDX_W'(rd_row) * IDX_W'(TILE_COLS) + IDX_W'(rd_col)) : '0;
    assign rd_tile = map_q[rd_idx];

    assign wr_ok  = wr_en && (state_q == S_RUN) &&
                    (32'(wr_col) < TILE_COLS) && (32'(wr_row) < TILE_ROWS);
    assign wr_idx = wr_ok ? (IDX_W'(wr_row) * IDX_W'(TILE_COLS) + IDX_W'(wr_col)) : '0;

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            map_q[clr_idx_q] <= CLEAR_VAL;
        end else if (wr_ok) begin
            map_q[wr_idx] <= wr_tile;
        end
    end

    assign vis_in = valid_in && rd_inr && (state_q == S_RUN);

`ifdef GRID_OVERLAY_EN
    logic [L-1:0] grid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            grid_q <= '0;
        end else begin
            grid_q <= {grid_q[L-2:0], (h_cnt[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0)};
        end
    end

    assign pix = grid_q[L-2] ? 12'h888 : rom_data;
`else
    assign pix = rom_data;
`endif

    // Stage L-2 of the delay line pairs with rom_data, so RGB lands on the same edge as stage L-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            vld_q      <= '0;
            hs_q       <= '1;
            vs_q       <= '1;
            rgb_q      <= '0;
        end else begin
            rom_addr_q <= {rd_tile, v_cnt[4:0], h_cnt[4:0]};
            vld_q      <= {vld_q[L-2:0], vis_in};
            hs_q       <= {hs_q[L-2:0], hsync_in};
            vs_q       <= {vs_q[L-2:0], vsync_in};
            rgb_q      <= vld_q[L-2] ? pix : '0;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign vgaRed    = rgb_q[11:8];
    assign vgaGreen  = rgb_q[7:4];
    assign vgaBlue   = rgb_q[3:0];
    assign hsync_out = hs_q[L-1];
    assign vsync_out = vs_q[L-1];
endmodule

// File: doc/tile_renderer.md
Name: tile_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing controller on the 25 MHz pixel clock.
- Holds the 20x15 tile map of 4-bit picture numbers (32x32-pixel tiles covering 640x480).
- Converts h_cnt/v_cnt into a tile-ROM address and registers the returned 12-bit colour onto vgaRed/vgaGreen/vgaBlue.
- Delays hsync/vsync/valid so they stay aligned with the colour.
- Game logic updates tiles through a single write port.

Parameters:
- TILE_COLS, 20, tile columns in the map
- TILE_ROWS, 15, tile rows in the map
- ROM_LAT, 1, read latency of the external tile ROM in clk cycles (1..3)
- CLEAR_VAL, 4'd1, picture number written to every map entry by the clear sequence

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  reset, synchronous, active-high
- valid_in  in  1  active-video flag from the VGA controller
- hsync_in  in  1  hsync from the VGA controller, active-low
- vsync_in  in  1  vsync from the VGA controller, active-low
- h_cnt  in  10  pixel column, 0..799
- v_cnt  in  10  pixel row, 0..524
- wr_en  in  1  tile write strobe
- wr_col  in  5  tile column to write
- wr_row  in  4  tile row to write
- wr_tile  in  4  picture number to write
- busy  out  1  high while the clear sequence runs
- rom_addr  out  14  {tile[3:0], v_cnt[4:0], h_cnt[4:0]}
- rom_data  in  12  {R,G,B} from the tile ROM, valid ROM_LAT cycles after rom_addr
- vgaRed  out  4  red
- vgaGreen  out  4  green
- vgaBlue  out  4  blue
- hsync_out  out  1  hsync aligned to RGB
- vsync_out  out  1  vsync aligned to RGB

Behaviour:
- Map storage: 300 x 4-bit entries, index = row*20 + col.
- FSM states CLEAR and RUN.
  - rst forces CLEAR with clear index 0.
  - In CLEAR: one entry per cycle is written with CLEAR_VAL, index 0..299; after writing 299 the FSM moves to RUN.
  - The clear sequence takes exactly 300 cycles after rst deasserts. busy=1 in CLEAR, 0 in RUN.
  - rst asserted mid-clear or mid-frame restarts CLEAR at index 0.
- Write port: honoured only in RUN with wr_col<20 and wr_row<15; the entry updates at the next clk edge. Writes in CLEAR or out of range are dropped silently, with no queueing.
- Pipeline, with inputs sampled at edge N:
  - Stage 1 (edge N): col = h_cnt[9:5], row = v_cnt[8:5], map read; rom_addr registered, valid at N+1.
  - rom_data is valid at N+1+ROM_LAT.
  - RGB is registered at edge N+2+ROM_LAT.
  - Total latency L = 2+ROM_LAT cycles.
- valid, hsync and vsync pass through an L-stage delay line, so hsync_out/vsync_out/RGB stay mutually aligned.
- RGB is forced to 0 when:
  - the delayed valid is 0, or
  - the delayed in-range flag is 0 (col>=20 or row>=15), or
  - the FSM was in CLEAR when the pixel was sampled.
- Map read and write of the same entry in one cycle: the read returns the old value; the new value is visible from the next cycle.
- Reset values:
  - RGB = 0
  - rom_addr = 0
  - busy = 1
  - hsync_out = vsync_out = 1
  - all delay-line stages reset to valid=0, hsync=1, vsync=1
- The clear sequence does not stall the pipeline. Sync outputs keep tracking the inputs through CLEAR, with RGB black.

Optional Feature:
- Macro: GRID_OVERLAY_EN.
- Defined: pixels with in-tile offset x==0 or y==0 (h_cnt[4:0]==0 or v_cnt[4:0]==0) output 12'h888 instead of rom_data, when otherwise visible. The offset flags are carried through the same L-stage delay.
- Undefined: no overlay; the ROM colour is always used; no extra registers.

Test Plan:
- Reset, then release with valid_in=1 -> busy=1 for exactly 300 cycles, then 0; RGB=0 throughout CLEAR; hsync_out equals hsync_in delayed L=3 (ROM_LAT=1).
- After clear, h_cnt=37, v_cnt=70 -> rom_addr=14'h04C5 one cycle later (tile 1, y=6, x=5); a ROM model returning 12'hA5C -> vgaRed=A, vgaGreen=5, vgaBlue=C at N+3.
- wr_en with col=19, row=14, tile=7, then h_cnt=639, v_cnt=479 -> rom_addr[13:10]=7. The same write with col=20 is ignored; the entry stays at CLEAR_VAL.
- Write to tile (0,0) in the same cycle that pixel (0,0) is sampled -> old tile number in rom_addr; the next sampled pixel (1,0) uses the new number.
- valid_in=0 or h_cnt=700 -> RGB=0 at N+L. rst asserted mid-frame -> outputs return to reset values next edge and busy restarts its 300-cycle count.
- GRID_OVERLAY_EN defined: pixel (32,40) -> RGB=12'h888; pixel (33,40) -> ROM colour. Undefined: both show ROM colour.
